seq_divider: RTL and testbench

Multi-cycle 16-bit unsigned divider that supplies the ALU's divide operation (`alu_func` 4'b1000) with a registered quotient and a completion strobe. The ALU's `div_done`/`div_result` inputs connect here, replacing the single-cycle combinational `/`. Operand order matches the ALU: result = dividend (B side) / divisor (A side). One bit is produced per clock using the restoring algorithm, behind a start/busy/done handshake.

---
 rtl/seq_divider_if.sv | 23 ++
 rtl/seq_divider.sv | 141 ++++++++++++++
 tb/tb_seq_divider.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Handshake and data bundle between the ALU (master) and seq_divider (slave).
interface seq_divider_if #(
   parameter int unsigned WIDTH = 16
);
   logic             div_start;
   logic [WIDTH-1:0] div_b;
   logic [WIDTH-1:0] div_a;
   logic             div_busy;
   logic             div_done;
   logic [WIDTH-1:0] div_result;
   logic [WIDTH-1:0] div_rem;
   logic             div_dz;

   modport master (
      output div_start, div_b, div_a,
      input  div_busy, div_done, div_result, div_rem, div_dz
   );

   modport slave (
      input  div_start, div_b, div_a,
      output div_busy, div_done, div_result, div_rem, div_dz
   );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring unsigned divider, one quotient bit per clock.
// result = div_b / div_a, remainder = div_b % div_a; divide by zero yields
// quotient all ones and remainder = dividend, with div_dz set.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor completes one edge after the
// start is accepted instead of running all WIDTH iterations.
module seq_divider #(
   parameter int unsigned WIDTH = 16
) (
   input logic         clk,
   input logic         rst_n,
   seq_divider_if.slave dif
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   prem_q, prem_d;
   // Dividend bits shift out of the top while quotient bits shift in at the bottom.
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] rmd_q, rmd_d;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic             qbit;
   logic [WIDTH-1:0] quo_next;
   logic [WIDTH:0]   prem_next;
   logic             fast_zero;

   // quo_q still holds the untouched dividend on the first RUN cycle, so the
   // fast path can report it directly as the remainder.
`ifdef DIV_ZERO_FAST_EN
   assign fast_zero = (dvs_q == '0);
`else
   assign fast_zero = 1'b0;
`endif

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      shifted   = {prem_q[WIDTH-1:0], quo_q[WIDTH-1]};
      trial     = shifted - {1'b0, dvs_q};
      qbit      = (shifted >= {1'b0, dvs_q});
      quo_next  = {quo_q[WIDTH-2:0], qbit};
      prem_next = qbit ? trial : shifted;
   end

   // Next-state, working-register and output-register updates.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      prem_d  = prem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dz_d    = dz_q;
      res_d   = res_q;
      rmd_d   = rmd_q;

      case (state_q)
         ST_IDLE: begin
            if (dif.div_start) begin
               quo_d   = dif.div_b;
               dvs_d   = dif.div_a;
               prem_d  = '0;
               cnt_d   = CW'(WIDTH);
               busy_d  = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (fast_zero) begin
               res_d   = '1;
               rmd_d   = quo_q;
               dz_d    = 1'b1;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               prem_d = prem_next;
               quo_d  = quo_next;
               cnt_d  = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  res_d   = quo_next;
                  rmd_d   = prem_next[WIDTH-1:0];
                  dz_d    = (dvs_q == '0);
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and register bank with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         prem_q  <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
         res_q   <= '0;
         rmd_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prem_q  <= prem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
         res_q   <= res_d;
         rmd_q   <= rmd_d;
      end
   end

   assign dif.div_busy   = busy_q;
   assign dif.div_done   = done_q;
   assign dif.div_result = res_q;
   assign dif.div_rem    = rmd_q;
   assign dif.div_dz     = dz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider: scoreboard of expected completions, monitor on the
// falling edge, directed cases followed by a randomized sweep.
module tb_seq_divider;
   localparam int unsigned W = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seq_divider_if #(.WIDTH(W)) dif ();

   seq_divider #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .dif   (dif)
   );

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      int unsigned  done_cyc;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc       = 0;
   int unsigned next_free = 0;
   int unsigned busy_end  = 0;
   int unsigned accepts   = 0;
   int unsigned n_checks  = 0;
   int unsigned n_pass    = 0;
   logic [W-1:0] last_q  = '0;
   logic [W-1:0] last_r  = '0;
   logic         last_dz = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic fail_event(input string name);
      n_checks++;
      $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
   endtask

   // Reference: acceptance timing and arithmetic result, evaluated on each rising edge.
   always @(posedge clk) begin
      exp_t        e;
      int unsigned lat;
      cyc++;
      if (rst_n && dif.div_start && cyc >= next_free) begin
         if (dif.div_a == '0) begin
            e.q = '1;
            e.r = dif.div_b;
         end else begin
            e.q = dif.div_b / dif.div_a;
            e.r = dif.div_b % dif.div_a;
         end
         e.dz = (dif.div_a == '0);
`ifdef DIV_ZERO_FAST_EN
         lat = (dif.div_a == '0) ? 1 : W;
`else
         lat = W;
`endif
         e.done_cyc = cyc + lat;
         sb.push_back(e);
         busy_end  = cyc + lat;
         next_free = cyc + lat + 1;
         accepts++;
      end
   end

   // Monitor: compares completions against the scoreboard and checks held outputs.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         check("busy", 32'(dif.div_busy), 32'(cyc < busy_end));
         if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
            n_checks++;
            $display("FAIL done_timeout: got no div_done expected one at cycle %0d", sb[0].done_cyc);
            void'(sb.pop_front());
         end
         if (dif.div_done) begin
            if (sb.size() == 0) begin
               fail_event("unexpected_done");
            end else begin
               e = sb.pop_front();
               check("done_cycle", cyc, e.done_cyc);
               check("quotient", 32'(dif.div_result), 32'(e.q));
               check("remainder", 32'(dif.div_rem), 32'(e.r));
               check("div_dz", 32'(dif.div_dz), 32'(e.dz));
               last_q  = e.q;
               last_r  = e.r;
               last_dz = e.dz;
            end
         end else begin
            check("hold_result", 32'(dif.div_result), 32'(last_q));
            check("hold_rem", 32'(dif.div_rem), 32'(last_r));
            check("hold_dz", 32'(dif.div_dz), 32'(last_dz));
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 32'(dif.div_busy), 32'd0);
      check({tag, "_done"}, 32'(dif.div_done), 32'd0);
      check({tag, "_result"}, 32'(dif.div_result), 32'd0);
      check({tag, "_rem"}, 32'(dif.div_rem), 32'd0);
      check({tag, "_dz"}, 32'(dif.div_dz), 32'd0);
   endtask

   task automatic wait_idle();
      int unsigned n = 0;
      while ((sb.size() != 0 || cyc < next_free) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         n_checks++;
         $display("FAIL idle_timeout: got busy expected idle within 200 cycles");
      end
   endtask

   task automatic wait_accepts(input int unsigned target);
      int unsigned n = 0;
      while (accepts < target && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         n_checks++;
         $display("FAIL accept_timeout: got %0d accepts expected %0d", accepts, target);
      end
   endtask

   task automatic start_op(input logic [W-1:0] b, input logic [W-1:0] a);
      @(negedge clk);
      dif.div_b     = b;
      dif.div_a     = a;
      dif.div_start = 1'b1;
      @(negedge clk);
      dif.div_start = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      sb.delete();
      busy_end  = 0;
      next_free = 0;
      last_q    = '0;
      last_r    = '0;
      last_dz   = 1'b0;
   endtask

   initial begin
      int unsigned target;
      int unsigned guard;
      int unsigned sel;
      dif.div_start = 1'b0;
      dif.div_b     = '0;
      dif.div_a     = '0;
      apply_reset();
      repeat (3) @(negedge clk);
      #1 check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // 100 / 7
      start_op(16'd100, 16'd7);
      wait_idle();

      // back-to-back with start held high
      @(negedge clk);
      target = accepts;
      dif.div_b = 16'hFFFF;
      dif.div_a = 16'h0001;
      dif.div_start = 1'b1;
      wait_accepts(target + 1);
      dif.div_b = 16'h0005;
      dif.div_a = 16'h0009;
      wait_accepts(target + 2);
      dif.div_start = 1'b0;
      wait_idle();

      // divide by zero
      start_op(16'h1234, 16'h0000);
      wait_idle();

      // start while busy is ignored
      start_op(16'd50, 16'd5);
      repeat (3) @(negedge clk);
      dif.div_b = 16'd9;
      dif.div_a = 16'd3;
      dif.div_start = 1'b1;
      @(negedge clk);
      dif.div_start = 1'b0;
      wait_idle();
      repeat (20) @(negedge clk);

      // asynchronous reset mid-operation
      start_op(16'd1000, 16'd3);
      repeat (6) @(negedge clk);
      #2 apply_reset();
      #1 check_all_zero("midop_reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      start_op(16'd1000, 16'd3);
      wait_idle();

      // randomized sweep
      target = accepts + 2000;
      guard  = 0;
      while (accepts < target && guard < 70000) begin
         @(negedge clk);
         guard++;
         sel = $urandom_range(0, 9);
         dif.div_start = ($urandom_range(0, 9) != 0);
         dif.div_b     = W'($urandom);
         if (sel == 0)      dif.div_a = '0;
         else if (sel < 3)  dif.div_a = W'($urandom_range(1, 15));
         else if (sel < 5)  dif.div_a = dif.div_b + W'($urandom_range(0, 3));
         else               dif.div_a = W'($urandom);
      end
      if (accepts < target) begin
         n_checks++;
         $display("FAIL sweep_timeout: got %0d accepts expected %0d", accepts, target);
      end
      @(negedge clk);
      dif.div_start = 1'b0;
      wait_idle();
      repeat (5) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
